// File: rtl/reg_share_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM encoding,
// gap-counter sizing and an index-width helper.
package reg_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int MAX_GAP = 15;
  localparam int CNT_W   = 4;

  // Index width that stays at least one bit wide.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester/shared-register bundle for reg_share_arbiter.
// The master side is the requester population, the slave side is the arbiter.
interface reg_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1
);
  import reg_share_pkg::*;

  localparam int IDW = id_width(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   reg_en;
  logic [WIDTH-1:0]       reg_d;
  logic                   busy;
  logic [IDW-1:0]         last_id;

  modport master (
    output req, wdata,
    input  gnt, reg_en, reg_d, busy, last_id
  );

  modport slave (
    input  req, wdata,
    output gnt, reg_en, reg_d, busy, last_id
  );

endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to index 0, found by a double-width masked priority search.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             valid
);

  logic [N_REQ-1:0]   mask;
  logic [2*N_REQ-1:0] dbl;
  int                 sel;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign mask[gi] = (ptr <= IDW'(gi));
    end
  endgenerate

  // Lower half holds only requests at/above ptr; the upper half is the
  // unmasked wrap-around copy, so the lowest set bit is the winner.
  assign dbl = {req, req & mask};

  always_comb begin
    sel = 0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (dbl[i]) sel = i;
    end
  end

  assign winner = (sel >= N_REQ) ? IDW'(sel - N_REQ) : IDW'(sel);
  assign valid  = |req;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin controller sharing one enabled D-register among N_REQ
// requesters: one-cycle write strobe followed by GAP idle cycles.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1,
  parameter int GAP   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_share_arbiter_if.slave bus
);

  localparam int IDW = id_width(N_REQ);

  state_t             state_reg, state_next;
  logic [IDW-1:0]     ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic               en_reg, en_next;
  logic [WIDTH-1:0]   d_reg, d_next;
  logic [IDW-1:0]     last_reg, last_next;

  logic [IDW-1:0]     win;
  logic               win_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .winner (win),
    .valid  (win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      en_reg    <= 1'b0;
      d_reg     <= '0;
      last_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      en_reg    <= en_next;
      d_reg     <= d_next;
      last_reg  <= last_next;
    end
  end

  // gnt/reg_en default low so they can only be high for the WRITE cycle.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = '0;
    en_next    = 1'b0;
    d_next     = d_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          gnt_next   = N_REQ'(1) << win;
          en_next    = 1'b1;
          d_next     = bus.wdata[int'(win)*WIDTH +: WIDTH];
          last_next  = win;
          ptr_next   = (win == IDW'(N_REQ-1)) ? '0 : IDW'(win + 1'b1);
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (GAP > 0) begin
          state_next = ST_GAP;
          cnt_next   = CNT_W'(GAP - 1);
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.gnt     = gnt_reg;
  assign bus.reg_en  = en_reg;
  assign bus.reg_d   = d_reg;
  assign bus.busy    = (state_reg != ST_IDLE);
  assign bus.last_id = last_reg;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: table of per-cycle vectors on a
// GAP=2 instance, plus hand sequences for async reset and a GAP=0 instance.
module tb_reg_share_arbiter;

  logic clk;
  logic rst_n;

  reg_share_arbiter_if #(.N_REQ(4), .WIDTH(1)) bus  ();
  reg_share_arbiter_if #(.N_REQ(4), .WIDTH(1)) bus0 ();

  reg_share_arbiter #(.N_REQ(4), .WIDTH(1), .GAP(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  reg_share_arbiter #(.N_REQ(4), .WIDTH(1), .GAP(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared register that sits behind the arbiter.
  logic q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          q <= 1'b0;
    else if (bus.reg_en) q <= bus.reg_d;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] wdata;
    logic [3:0] gnt;
    logic       en;
    logic       d;
    logic       busy;
    logic [1:0] last;
    logic       q;
  } vec_t;

  vec_t vecs[$];
  int   applied    = 0;
  int   miscompares = 0;

  task automatic add(input logic [3:0] r, input logic [3:0] w, input logic [3:0] g,
                     input logic e, input logic d, input logic b, input logic [1:0] l,
                     input logic qq);
    vec_t v;
    v.req = r; v.wdata = w; v.gnt = g; v.en = e; v.d = d; v.busy = b; v.last = l; v.q = qq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input int idx, input logic [3:0] g,
                            input logic e, input logic d, input logic b,
                            input logic [1:0] l);
    chk({tag, "_gnt"},  idx, 32'(bus.gnt), 32'(g));
    chk({tag, "_en"},   idx, 32'(bus.reg_en), 32'(e));
    chk({tag, "_d"},    idx, 32'(bus.reg_d), 32'(d));
    chk({tag, "_busy"}, idx, 32'(bus.busy), 32'(b));
    chk({tag, "_last"}, idx, 32'(bus.last_id), 32'(l));
  endtask

  initial begin
    logic prev_en;
    logic bit_d;

    // fairness from ptr=0, wdata[i] = 1010 bit i
    add(4'b1111, 4'b1010, 4'b0001, 1, 0, 1, 0, 0);
    add(4'b1111, 4'b1010, 4'b0000, 0, 0, 1, 0, 0);
    add(4'b1111, 4'b1010, 4'b0000, 0, 0, 1, 0, 0);
    add(4'b1111, 4'b1010, 4'b0000, 0, 0, 0, 0, 0);
    add(4'b1111, 4'b1010, 4'b0010, 1, 1, 1, 1, 0);
    add(4'b1111, 4'b1010, 4'b0000, 0, 1, 1, 1, 1);
    add(4'b1111, 4'b1010, 4'b0000, 0, 1, 1, 1, 1);
    add(4'b1111, 4'b1010, 4'b0000, 0, 1, 0, 1, 1);
    add(4'b1111, 4'b1010, 4'b0100, 1, 0, 1, 2, 1);
    add(4'b1111, 4'b1010, 4'b0000, 0, 0, 1, 2, 0);
    add(4'b1111, 4'b1010, 4'b0000, 0, 0, 1, 2, 0);
    add(4'b1111, 4'b1010, 4'b0000, 0, 0, 0, 2, 0);
    add(4'b1111, 4'b1010, 4'b1000, 1, 1, 1, 3, 0);
    add(4'b1111, 4'b1010, 4'b0000, 0, 1, 1, 3, 1);
    add(4'b1111, 4'b1010, 4'b0000, 0, 1, 1, 3, 1);
    add(4'b1111, 4'b1010, 4'b0000, 0, 1, 0, 3, 1);
    add(4'b1111, 4'b1010, 4'b0001, 1, 0, 1, 0, 1);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 0, 0, 0);
    // wrap skip: winner 1 leaves ptr=2, then 1001 -> 3 then 0
    add(4'b0010, 4'b1010, 4'b0010, 1, 1, 1, 1, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 1, 1, 1, 1);
    add(4'b0000, 4'b1010, 4'b0000, 0, 1, 1, 1, 1);
    add(4'b0000, 4'b1010, 4'b0000, 0, 1, 0, 1, 1);
    add(4'b1001, 4'b1010, 4'b1000, 1, 1, 1, 3, 1);
    add(4'b0001, 4'b1010, 4'b0000, 0, 1, 1, 3, 1);
    add(4'b0001, 4'b1010, 4'b0000, 0, 1, 1, 3, 1);
    add(4'b0001, 4'b1010, 4'b0000, 0, 1, 0, 3, 1);
    add(4'b0001, 4'b1010, 4'b0001, 1, 0, 1, 0, 1);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 0, 0, 0);
    // request raised during GAP is ignored until the IDLE edge
    add(4'b0010, 4'b1010, 4'b0010, 1, 1, 1, 1, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 1, 1, 1, 1);
    add(4'b0100, 4'b1010, 4'b0000, 0, 1, 1, 1, 1);
    add(4'b0100, 4'b1010, 4'b0000, 0, 1, 0, 1, 1);
    add(4'b0100, 4'b1010, 4'b0100, 1, 0, 1, 2, 1);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 1, 2, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 1, 2, 0);
    add(4'b0000, 4'b1010, 4'b0000, 0, 0, 0, 2, 0);
    // single request wdata[0]=1 with ptr=3 (wraps to 0)
    add(4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0, 0);
    add(4'b0000, 4'b0001, 4'b0000, 0, 1, 1, 0, 1);
    add(4'b0000, 4'b0001, 4'b0000, 0, 1, 1, 0, 1);
    add(4'b0000, 4'b0001, 4'b0000, 0, 1, 0, 0, 1);

    rst_n = 1'b0;
    bus.req = '0;  bus.wdata = '0;
    bus0.req = '0; bus0.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    applied++;
    check_main("reset", 0, 4'b0000, 0, 0, 0, 0);
    chk("reset_g0_busy", 0, 32'(bus0.busy), 32'd0);
    chk("reset_g0_en",   0, 32'(bus0.reg_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.req   = vecs[i].req;
      bus.wdata = vecs[i].wdata;
      @(posedge clk);
      #1;
      applied++;
      check_main("vec", i, vecs[i].gnt, vecs[i].en, vecs[i].d, vecs[i].busy, vecs[i].last);
      chk("vec_q", i, 32'(q), 32'(vecs[i].q));
      $display("vec %0d: req=%b gnt=%b en=%b d=%b busy=%b last=%0d q=%b",
               i, vecs[i].req, bus.gnt, bus.reg_en, bus.reg_d, bus.busy, bus.last_id, q);
    end

    // async reset during WRITE, then restart from ptr=0
    @(negedge clk);
    bus.req = 4'b1000; bus.wdata = 4'b1010;
    @(posedge clk);
    #1;
    applied++;
    check_main("pre_rst", 0, 4'b1000, 1, 1, 1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    applied++;
    check_main("mid_rst", 0, 4'b0000, 0, 0, 0, 0);
    $display("async reset mid-WRITE: gnt=%b en=%b busy=%b last=%0d",
             bus.gnt, bus.reg_en, bus.busy, bus.last_id);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1010;
    @(posedge clk);
    #1;
    applied++;
    check_main("post_rst", 0, 4'b0010, 1, 1, 1, 1);
    $display("after reset: req=1010 gnt=%b last=%0d", bus.gnt, bus.last_id);
    @(negedge clk);
    bus.req = '0;
    repeat (3) @(posedge clk);

    // GAP=0 instance: req=0010 held, wdata[1] alternates per grant
    prev_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bit_d = ((k / 2) % 2) == 1;
      @(negedge clk);
      bus0.req   = 4'b0010;
      bus0.wdata = {2'b00, bit_d, 1'b0};
      @(posedge clk);
      #1;
      applied++;
      chk("g0_gnt",  k, 32'(bus0.gnt), (k % 2 == 0) ? 32'h2 : 32'h0);
      chk("g0_en",   k, 32'(bus0.reg_en), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("g0_d",    k, 32'(bus0.reg_d), 32'(bit_d));
      chk("g0_busy", k, 32'(bus0.busy), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("g0_consec_en", k, 32'(prev_en & bus0.reg_en), 32'd0);
      $display("gap0 %0d: gnt=%b en=%b d=%b", k, bus0.gnt, bus0.reg_en, bus0.reg_d);
      prev_en = bus0.reg_en;
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
